pipe_hazard_ctrl: RTL

- Central stall/flush controller for the five-stage pipeline (F, D, E, M, W).
- Each cycle it produces per-register hold (stall) and clear (bubble) controls for the inter-stage registers F/D, D/E, E/M and M/W, including the D/E decode register.
- Sources it arbitrates: load-use hazards, instruction/data memory wait, a fixed-latency multicycle mul/div in E, and branch redirects from E.
- It owns a mul/div latency counter and a pending-redirect latch, so it sequences multi-cycle events rather than only decoding them.

---
 rtl/pipe_hazard_ctrl.sv | 116 +++++++++++
 1 files changed

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush controller for a five-stage F/D/E/M/W pipeline.
// Arbitrates data-memory wait, multicycle mul/div occupancy of E, load-use
// hazards and fetch wait. Branch redirects resolved in E are sequenced
// against fetch wait with a pending latch.
// Ports:
//   clk, reset                 rising-edge clock, async active-high reset
//   imem_busy, dmem_busy       fetch / data access not complete this cycle
//   d_rs1, d_rs2, d_uses_rs*   source operands of the instruction in D
//   e_is_load, e_rd            load flag and destination of the instruction in E
//   md_start                   one-cycle pulse: mul/div enters E
//   ex_redirect                mispredicted branch/jump resolved in E
//   stall_*/flush_*            hold / bubble controls per inter-stage register
//   pc_redirect                fetch takes the redirect target this cycle
//   md_busy                    mul/div occupancy in progress
module pipe_hazard_ctrl #(
  parameter int unsigned MD_LAT = 4,
  parameter int unsigned REG_W  = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             imem_busy,
  input  logic             dmem_busy,
  input  logic [REG_W-1:0] d_rs1,
  input  logic [REG_W-1:0] d_rs2,
  input  logic             d_uses_rs1,
  input  logic             d_uses_rs2,
  input  logic             e_is_load,
  input  logic [REG_W-1:0] e_rd,
  input  logic             md_start,
  input  logic             ex_redirect,
  output logic             stall_fd,
  output logic             stall_de,
  output logic             stall_em,
  output logic             stall_mw,
  output logic             flush_fd,
  output logic             flush_de,
  output logic             flush_em,
  output logic             flush_mw,
  output logic             pc_redirect,
  output logic             md_busy
);

  localparam int unsigned CNT_W = 4;
  localparam logic        MD_MULTI = (MD_LAT > 1);

  typedef enum logic {RUN, MD_WAIT} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] md_cnt_q, md_cnt_d;
  logic             redir_pend_q, redir_pend_d;

  logic md_hold, load_use, e_held, redir;

  // Hazard decode shared by outputs and next-state logic
  always_comb begin
    md_hold  = (state_q == MD_WAIT) || (md_start && MD_MULTI);
    load_use = e_is_load && (e_rd != '0) &&
               ((d_uses_rs1 && (d_rs1 == e_rd)) || (d_uses_rs2 && (d_rs2 == e_rd)));
    e_held   = dmem_busy || md_hold;
    // A redirect while E is held is dropped; E re-presents it once released
    redir    = (ex_redirect || redir_pend_q) && !e_held;
  end

  // Stall/flush resolution: only the highest active hold request bubbles,
  // and a redirect overrides the F/D and D/E holds of load-use / fetch wait
  always_comb begin
    stall_mw    = dmem_busy;
    stall_em    = e_held;
    stall_de    = e_held || (load_use && !redir);
    stall_fd    = e_held || ((load_use || imem_busy) && !redir);
    flush_mw    = dmem_busy;
    flush_em    = md_hold && !dmem_busy;
    flush_de    = redir || (load_use && !e_held);
    flush_fd    = redir || (imem_busy && !e_held && !load_use);
    pc_redirect = redir && !imem_busy;
    md_busy     = md_hold;
  end

  // Next state: mul/div countdown runs regardless of dmem wait
  always_comb begin
    state_d      = state_q;
    md_cnt_d     = md_cnt_q;
    redir_pend_d = redir_pend_q;
    case (state_q)
      RUN: begin
        if (md_start && MD_MULTI) begin
          state_d  = MD_WAIT;
          md_cnt_d = CNT_W'(MD_LAT - 2);
        end
      end
      MD_WAIT: begin
        if (md_cnt_q == '0) state_d  = RUN;
        else                md_cnt_d = md_cnt_q - CNT_W'(1);
      end
      default: state_d = RUN;
    endcase
    if (redir) redir_pend_d = imem_busy;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= RUN;
      md_cnt_q     <= '0;
      redir_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      md_cnt_q     <= md_cnt_d;
      redir_pend_q <= redir_pend_d;
    end
  end

  // A new mul/div may not start while one is still occupying E
  a_no_md_start_in_wait: assert property (@(posedge clk) disable iff (reset)
    !(md_start && state_q == MD_WAIT));

endmodule
